fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with single outstanding request and one-entry output buffer
//
// Purpose:
//   Sequential instruction fetch from a doubleword-wide instruction memory.
//   One request is outstanding at a time. Each returned doubleword is placed
//   in a one-entry buffer that feeds the instruction queue. Flush and branch
//   redirects retarget the fetch PC. A redirect that arrives while a request
//   is still in flight makes the FSM discard that response in DROP.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   flush, flush_pc           pipeline flush redirect and its target (wins over branch)
//   branch_pc_valid/branch_pc predictor redirect and its target
//   imem_req_valid/addr/ready instruction memory request (8-byte aligned address)
//   imem_rsp_valid/data       instruction memory response, one per accepted request
//   if_iq_valid/pc/instr      fetch packet toward the instruction queue
//   if_iq_ready               instruction queue accepts packet
//   fetch_busy                a request is outstanding (WAIT or DROP)

module fetch_ctrl #(
    parameter logic [63:0] RST_PC = 64'h0000_0000_8000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic [63:0] flush_pc,
    input  logic        branch_pc_valid,
    input  logic [63:0] branch_pc,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [63:0] imem_rsp_data,
    output logic        if_iq_valid,
    output logic [63:0] if_iq_pc,
    output logic [63:0] if_iq_instr,
    input  logic        if_iq_ready,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [63:0] buf_pc_q, buf_pc_d;
    logic [63:0] buf_instr_q, buf_instr_d;

    logic        redirect;
    logic [63:0] redirect_pc;
    logic        drain;
    logic        req_fire;

    assign redirect    = flush | branch_pc_valid;
    assign redirect_pc = flush ? flush_pc : branch_pc;
    assign drain       = buf_valid_q & if_iq_ready;

    assign imem_req_addr = {fetch_pc_q[63:3], 3'b000};

    // Output buffer and busy are forced low while reset is held so the
    // outputs are defined even before the first reset edge.
    assign if_iq_valid = ~RST & buf_valid_q;
    assign if_iq_pc    = RST ? 64'd0 : buf_pc_q;
    assign if_iq_instr = RST ? 64'd0 : buf_instr_q;
    assign fetch_busy  = ~RST & ((state_q == WAIT) | (state_q == DROP));

    always_comb begin
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        req_pc_d       = req_pc_q;
        buf_valid_d    = buf_valid_q & ~drain;
        buf_pc_d       = buf_pc_q;
        buf_instr_d    = buf_instr_q;

        // A new request may only issue if its response will find the buffer
        // empty: either it is empty now or it is handed off this cycle.
        if (!RST && state_q == REQ && !redirect && (!buf_valid_q || if_iq_ready)) begin
            imem_req_valid = 1'b1;
        end
        req_fire = imem_req_valid & imem_req_ready;

        if (redirect) begin
            fetch_pc_d  = redirect_pc;
            buf_valid_d = 1'b0;
            // A request still in flight must have its response swallowed;
            // a response arriving this very cycle is simply ignored.
            if ((state_q == WAIT || state_q == DROP) && !imem_rsp_valid) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (req_fire) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = {fetch_pc_q[63:3], 3'b000} + 64'd8;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = req_pc_q;
                        buf_instr_d = imem_rsp_data;
                        state_d     = REQ;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RST_PC;
            req_pc_q    <= 64'd0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 64'd0;
            buf_instr_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard testbench for fetch_ctrl

module tb_fetch_ctrl;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic [63:0] flush_pc;
    logic        branch_pc_valid;
    logic [63:0] branch_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [63:0] imem_rsp_data;
    logic        if_iq_valid;
    logic [63:0] if_iq_pc;
    logic [63:0] if_iq_instr;
    logic        if_iq_ready;
    logic        fetch_busy;

    fetch_ctrl #(.RST_PC(RST_PC)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .branch_pc_valid(branch_pc_valid),
        .branch_pc      (branch_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_iq_valid    (if_iq_valid),
        .if_iq_pc       (if_iq_pc),
        .if_iq_instr    (if_iq_instr),
        .if_iq_ready    (if_iq_ready),
        .fetch_busy     (fetch_busy)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int deliveries = 0;

    int mem_lat = 0;        // fixed response latency, or -1 for random
    bit mem_rdy_rand = 1'b0;

    logic [63:0] exp_q[$];  // expected packet PCs, in delivery order

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] align8(input logic [63:0] a);
        return a & ~64'd7;
    endfunction

    // After a redirect or reset the stream restarts at the target PC and
    // then continues through consecutive aligned doublewords.
    function automatic void rebuild(input logic [63:0] target);
        logic [63:0] p;
        exp_q.delete();
        exp_q.push_back(target);
        p = align8(target);
        for (int i = 0; i < 32; i++) begin
            p = p + 64'd8;
            exp_q.push_back(p);
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input string nm, output logic [63:0] a);
        int n;
        n = 0;
        a = 64'd0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(imem_req_valid && imem_req_ready) && n < 100);
        if (imem_req_valid && imem_req_ready) begin
            a = imem_req_addr;
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no request within 100 cycles", nm);
        end
    endtask

    task automatic wait_deliv(input string nm, input int target);
        int n;
        n = 0;
        while (deliveries < target && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, 64'(deliveries >= target), 64'd1);
    endtask

    // Memory model: one pending request, response after a fixed or random latency.
    initial begin : memory
        bit          s_acc, s_rsp, s_rst, pend;
        logic [63:0] s_addr, paddr;
        int          lat;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 64'd0;
        imem_req_ready = 1'b1;
        pend = 1'b0;
        paddr = 64'd0;
        lat = 0;
        forever begin
            @(negedge CLK);
            s_acc  = imem_req_valid && imem_req_ready;
            s_addr = imem_req_addr;
            s_rsp  = imem_rsp_valid;
            s_rst  = RST;
            @(posedge CLK);
            #1;
            if (s_rst) begin
                pend = 1'b0;
                imem_rsp_valid = 1'b0;
            end else begin
                if (s_rsp) begin
                    imem_rsp_valid = 1'b0;
                    pend = 1'b0;
                end
                if (s_acc) begin
                    pend  = 1'b1;
                    paddr = s_addr;
                    lat   = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (pend && !imem_rsp_valid) begin
                    if (lat == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_fn(paddr);
                    end else begin
                        lat--;
                    end
                end
            end
            imem_req_ready = mem_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted packet, and checks that a
    // stalled packet stays put and that no request issues while it waits.
    initial begin : monitor
        bit          stall_prev;
        logic [63:0] stall_pc, stall_instr, e;
        stall_prev = 1'b0;
        stall_pc = 64'd0;
        stall_instr = 64'd0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev && if_iq_valid) begin
                chk("stall_pc", if_iq_pc, stall_pc);
                chk("stall_instr", if_iq_instr, stall_instr);
            end
            if (if_iq_valid && !if_iq_ready) begin
                chk("req_while_full", 64'(imem_req_valid), 64'd0);
            end
            if (if_iq_valid && if_iq_ready) begin
                deliveries++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pkt_unexpected: got pc %h expected none", if_iq_pc);
                end else begin
                    if (exp_q.size() < 2) begin
                        exp_q.push_back(align8(exp_q[$]) + 64'd8);
                    end
                    e = exp_q.pop_front();
                    chk("pkt_pc", if_iq_pc, e);
                    chk("pkt_instr", if_iq_instr, mem_fn(align8(e)));
                end
            end
            stall_prev  = if_iq_valid && !if_iq_ready && !flush && !branch_pc_valid;
            stall_pc    = if_iq_pc;
            stall_instr = if_iq_instr;
        end
    end

    initial begin : stimulus
        logic [63:0] a, tgt_prev, f_t, b_t;
        bit          rst_prev, redir_prev;
        int          d0, r, sel;

        RST = 1'b1;
        flush = 1'b0;
        flush_pc = 64'd0;
        branch_pc_valid = 1'b0;
        branch_pc = 64'd0;
        if_iq_ready = 1'b1;

        // Reset values
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_iq_valid", 64'(if_iq_valid), 64'd0);
        chk("rst_busy", 64'(fetch_busy), 64'd0);
        chk("rst_iq_pc", if_iq_pc, 64'd0);
        chk("rst_iq_instr", if_iq_instr, 64'd0);
        @(posedge CLK);
        rebuild(RST_PC);
        #1 RST = 1'b0;

        // IDLE for one cycle, then the first request at the reset PC
        @(negedge CLK);
        chk("idle_no_req", 64'(imem_req_valid), 64'd0);
        @(negedge CLK);
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_req_addr, 64'h8000_0000);
        wait_deliv("first3_delivered", 3);

        // Back-pressure: buffer holds, no request issues
        @(posedge CLK);
        #1 if_iq_ready = 1'b0;
        repeat (8) @(negedge CLK);
        chk("stall_buf_full", 64'(if_iq_valid), 64'd1);
        @(posedge CLK);
        #1 if_iq_ready = 1'b1;

        // Branch redirect while a request is outstanding
        mem_lat = 2;
        wait_req("req_before_branch", a);
        @(posedge CLK);
        #1;
        branch_pc_valid = 1'b1;
        branch_pc = 64'h8000_0106;
        @(negedge CLK);
        chk("busy_in_wait", 64'(fetch_busy), 64'd1);
        @(posedge CLK);
        rebuild(64'h8000_0106);
        d0 = deliveries;
        #1 branch_pc_valid = 1'b0;
        @(negedge CLK);
        chk("busy_in_drop", 64'(fetch_busy), 64'd1);
        chk("no_req_in_drop", 64'(imem_req_valid), 64'd0);
        wait_req("branch_req", a);
        chk("branch_req_addr", a, 64'h8000_0100);
        mem_lat = 0;
        wait_deliv("branch_pkts", d0 + 2);

        // Flush and branch together, coincident with the response
        wait_req("req_before_flush", a);
        @(posedge CLK);
        #1;
        flush = 1'b1;
        flush_pc = 64'h8000_1000;
        branch_pc_valid = 1'b1;
        branch_pc = 64'h8000_0200;
        @(negedge CLK);
        chk("busy_flush_cycle", 64'(fetch_busy), 64'd1);
        @(posedge CLK);
        rebuild(64'h8000_1000);
        d0 = deliveries;
        #1;
        flush = 1'b0;
        branch_pc_valid = 1'b0;
        @(negedge CLK);
        chk("busy_after_coincident", 64'(fetch_busy), 64'd0);
        chk("req_after_coincident", 64'(imem_req_valid), 64'd1);
        chk("flush_prio_addr", imem_req_addr, 64'h8000_1000);
        wait_deliv("flush_pkts", d0 + 2);

        // Address wrap at the top of the address space
        @(posedge CLK);
        #1;
        flush = 1'b1;
        flush_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        @(posedge CLK);
        rebuild(64'hFFFF_FFFF_FFFF_FFF8);
        d0 = deliveries;
        #1 flush = 1'b0;
        wait_req("wrap_req0", a);
        chk("wrap_addr0", a, 64'hFFFF_FFFF_FFFF_FFF8);
        wait_req("wrap_req1", a);
        chk("wrap_addr1", a, 64'd0);
        wait_deliv("wrap_pkts", d0 + 2);

        // Randomized phase
        mem_lat = -1;
        mem_rdy_rand = 1'b1;
        rst_prev = 1'b0;
        redir_prev = 1'b0;
        tgt_prev = 64'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge CLK);
            if (rst_prev) rebuild(RST_PC);
            else if (redir_prev) rebuild(tgt_prev);
            #1;
            RST = 1'b0;
            flush = 1'b0;
            branch_pc_valid = 1'b0;
            rst_prev = 1'b0;
            redir_prev = 1'b0;
            r = $urandom_range(0, 199);
            if (r < 1) begin
                RST = 1'b1;
                rst_prev = 1'b1;
            end else if (r < 14) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: f_t = {32'd0, 32'h8000_0000 + 32'($urandom_range(0, 255))};
                    1: f_t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                    default: f_t = {$urandom, $urandom};
                endcase
                b_t = {32'd0, 32'h8000_0000 + 32'($urandom_range(0, 4095))};
                sel = $urandom_range(1, 3);
                flush = sel[0];
                flush_pc = f_t;
                branch_pc_valid = sel[1];
                branch_pc = b_t;
                redir_prev = 1'b1;
                tgt_prev = flush ? f_t : b_t;
            end
            if_iq_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge CLK);
        if (rst_prev) rebuild(RST_PC);
        else if (redir_prev) rebuild(tgt_prev);
        #1;
        RST = 1'b0;
        flush = 1'b0;
        branch_pc_valid = 1'b0;
        if_iq_ready = 1'b1;

        // Fetch keeps making progress once redirects stop
        d0 = deliveries;
        repeat (100) @(negedge CLK);
        chk("final_progress", 64'(deliveries > d0 + 10), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
